i2s_tone_tx: RTL and testbench

//  Serializes signed 24-bit audio samples (tone generator output) into an I2S

---
 rtl/i2s_tone_tx_if.sv | 30 +++
 rtl/i2s_tone_tx.sv | 108 ++++++++++
 tb/tb_i2s_tone_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tone_tx_if.sv
// Sample/stream bundle for i2s_tone_tx: the sample pair in, sample_ready back, I2S lines out.
// The slave modport is the transmitter; the master modport is the tone source / DAC side.
interface i2s_tone_tx_if #(
  parameter int unsigned SAMPLE_W = 24
);
  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic                sample_ready;
  logic                bclk;
  logic                lrclk;
  logic                sdata;

  modport master (
    output left_in,
    output right_in,
    input  sample_ready,
    input  bclk,
    input  lrclk,
    input  sdata
  );

  modport slave (
    input  left_in,
    input  right_in,
    output sample_ready,
    output bclk,
    output lrclk,
    output sdata
  );
endinterface

// File: rtl/i2s_tone_tx.sv
// I2S serializer: divides clk into BCLK/LRCLK and shifts out one latched L/R pair per 64-slot frame.
// Optional macro I2S_TX_MONO_EN: right slot repeats the left word and right_in is ignored.
module i2s_tone_tx #(
  parameter int unsigned BCLK_DIV = 8,
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic           clk,
  input  logic           reset,
  i2s_tone_tx_if.slave   io_bus
);

  localparam int unsigned     DivW     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax   = DivW'(BCLK_DIV - 1);
  localparam logic [4:0]      SlotLast = 5'(SAMPLE_W);

  logic [DivW-1:0]     r_div_cnt;
  logic                r_bclk;
  logic [5:0]          r_bit_cnt;
  logic                r_lrclk;
  logic                r_sdata;
  logic                r_sample_ready;
  logic [SAMPLE_W-1:0] r_word_l;

  logic [DivW-1:0]     w_div_cnt_d;
  logic                w_bclk_d;
  logic [5:0]          w_bit_cnt_d;
  logic                w_lrclk_d;
  logic                w_sdata_d;
  logic                w_sample_ready_d;
  logic [SAMPLE_W-1:0] w_word_l_d;
  logic                w_div_wrap;
  logic                w_fe;
  logic                w_frame_wrap;
  logic [4:0]          w_slot;
  logic [4:0]          w_idx;
  logic [31:0]         w_word_ext;
  logic                w_slot_bit;

`ifdef I2S_TX_MONO_EN
  // Right channel mirrors the left word, so right_in is intentionally dropped.
  logic w_unused_right;
  assign w_unused_right = ^io_bus.right_in;
`else
  logic [SAMPLE_W-1:0] r_word_r;
  logic [SAMPLE_W-1:0] w_word_r_d;
`endif

  always_comb begin
    w_div_wrap   = (r_div_cnt == DivMax);
    w_fe         = w_div_wrap & r_bclk;
    w_frame_wrap = w_fe & (r_bit_cnt == 6'd63);

    w_div_cnt_d  = w_div_wrap ? '0 : r_div_cnt + DivW'(1);
    w_bclk_d     = w_div_wrap ? ~r_bclk : r_bclk;
    w_bit_cnt_d  = w_fe ? r_bit_cnt + 6'd1 : r_bit_cnt;

    // Slot bit is chosen from the slot being entered; slot 0 of each half is the I2S delay bit.
    w_slot     = w_bit_cnt_d[4:0];
    w_idx      = SlotLast - w_slot;
    w_word_ext = '0;
`ifdef I2S_TX_MONO_EN
    w_word_ext[SAMPLE_W-1:0] = r_word_l;
`else
    w_word_ext[SAMPLE_W-1:0] = w_bit_cnt_d[5] ? r_word_r : r_word_l;
`endif
    w_slot_bit = ((w_slot != 5'd0) && (w_slot <= SlotLast)) ? w_word_ext[w_idx] : 1'b0;

    w_lrclk_d        = w_fe ? w_bit_cnt_d[5] : r_lrclk;
    w_sdata_d        = w_fe ? w_slot_bit : r_sdata;
    w_sample_ready_d = w_frame_wrap;
    w_word_l_d       = w_frame_wrap ? io_bus.left_in : r_word_l;
`ifndef I2S_TX_MONO_EN
    w_word_r_d       = w_frame_wrap ? io_bus.right_in : r_word_r;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt      <= '0;
      r_bclk         <= 1'b0;
      r_bit_cnt      <= 6'd63;
      r_lrclk        <= 1'b0;
      r_sdata        <= 1'b0;
      r_sample_ready <= 1'b0;
      r_word_l       <= '0;
`ifndef I2S_TX_MONO_EN
      r_word_r       <= '0;
`endif
    end else begin
      r_div_cnt      <= w_div_cnt_d;
      r_bclk         <= w_bclk_d;
      r_bit_cnt      <= w_bit_cnt_d;
      r_lrclk        <= w_lrclk_d;
      r_sdata        <= w_sdata_d;
      r_sample_ready <= w_sample_ready_d;
      r_word_l       <= w_word_l_d;
`ifndef I2S_TX_MONO_EN
      r_word_r       <= w_word_r_d;
`endif
    end
  end

  assign io_bus.bclk         = r_bclk;
  assign io_bus.lrclk        = r_lrclk;
  assign io_bus.sdata        = r_sdata;
  assign io_bus.sample_ready = r_sample_ready;

endmodule

// File: tb/tb_i2s_tone_tx.sv
// Self-checking bench for i2s_tone_tx: cycle-level reference model from frame arithmetic plus
// directed frame captures taken on bclk rising edges, the way a DAC would see them.
module tb_i2s_tone_tx;

  localparam int unsigned Div = 8;
  localparam int unsigned W   = 24;
`ifdef I2S_TX_MONO_EN
  localparam bit Mono = 1'b1;
`else
  localparam bit Mono = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  i2s_tone_tx_if #(.SAMPLE_W(W)) bus ();

  i2s_tone_tx #(
    .BCLK_DIV (Div),
    .SAMPLE_W (W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned n_edges  = 0;  // clk edges since reset release
  logic [W-1:0] m_left  = '0;
  logic [W-1:0] m_right = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slot index the frame counter holds after n_edges clocks: starts at 63, steps each bclk fall.
  function automatic int unsigned exp_slot();
    return (63 + n_edges / (2 * Div)) % 64;
  endfunction

  task automatic model_check();
    int unsigned  fe;
    int unsigned  b;
    int unsigned  s;
    logic [W-1:0] word;
    logic         e_bclk, e_lr, e_sd, e_rdy;
    fe     = n_edges / (2 * Div);
    b      = exp_slot();
    s      = b % 32;
    word   = (b >= 32) ? m_right : m_left;
    e_bclk = ((n_edges / Div) % 2) == 1;
    e_lr   = (fe > 0) && (b >= 32);
    e_sd   = (fe > 0) && (s >= 1) && (s <= W) ? word[W-s] : 1'b0;
    e_rdy  = (n_edges > 0) && (n_edges % (2 * Div) == 0) && (b == 0);
    check("bclk", bus.bclk, e_bclk);
    check("lrclk", bus.lrclk, e_lr);
    check("sdata", bus.sdata, e_sd);
    check("sample_ready", bus.sample_ready, e_rdy);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      n_edges = 0;
      m_left  = '0;
      m_right = '0;
    end else begin
      n_edges++;
      if ((n_edges % (2 * Div) == 0) && (exp_slot() == 0)) begin
        m_left  = bus.left_in;
        m_right = Mono ? bus.left_in : bus.right_in;
      end
    end
    #1;
    model_check();
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.sample_ready !== 1'b1 && cnt < 3000);
    check("ready_seen", bus.sample_ready, 1'b1);
  endtask

  task automatic wait_rise();
    logic prev;
    int   k;
    k = 0;
    do begin
      prev = bus.bclk;
      tick();
      k++;
    end while (!(prev === 1'b0 && bus.bclk === 1'b1) && k < 40);
    check("rise_seen", bus.bclk, 1'b1);
  endtask

  // Reset is already low; measure first bclk rise/fall relative to release.
  task automatic release_timing();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.bclk !== 1'b1 && k < 100);
    check("first_rise_clk", k, 8);
    do begin
      tick();
      k++;
    end while (bus.bclk !== 1'b0 && k < 100);
    check("first_fall_clk", k, 16);
    check("first_ready", bus.sample_ready, 1'b1);
    check("slot0_lrclk", bus.lrclk, 1'b0);
    check("slot0_sdata", bus.sdata, 1'b0);
  endtask

  // Captures one frame as the DAC sees it; optionally changes left_in at a given slot.
  task automatic capture_frame(input int chg_slot, input logic [W-1:0] new_left,
                               output logic [63:0] bits, output logic [63:0] lrs);
    int cnt;
    wait_ready(cnt);
    for (int sl = 0; sl < 64; sl++) begin
      wait_rise();
      bits[sl] = bus.sdata;
      lrs[sl]  = bus.lrclk;
      if (sl == chg_slot) bus.left_in = new_left;
    end
  endtask

  task automatic check_frame(input string tag, input logic [63:0] bits, input logic [63:0] lrs,
                             input logic [W-1:0] exp_l, input logic [W-1:0] exp_r);
    logic [W-1:0] lw, rw;
    logic         pad;
    pad = bits[0] | bits[32];
    for (int i = 0; i < int'(W); i++) begin
      lw[W-1-i] = bits[1+i];
      rw[W-1-i] = bits[33+i];
    end
    for (int i = int'(W) + 1; i < 32; i++) pad = pad | bits[i] | bits[32+i];
    check({tag, "_left"}, lw, exp_l);
    check({tag, "_right"}, rw, exp_r);
    check({tag, "_pad"}, pad, 1'b0);
    check({tag, "_lr_left"}, lrs[31:0], 32'h0);
    check({tag, "_lr_right"}, lrs[63:32], 32'hFFFF_FFFF);
  endtask

  initial begin
    logic [63:0]  bits, lrs;
    logic [W-1:0] l0, r0, l1;
    int           cnt;

    bus.left_in  = '0;
    bus.right_in = '0;

    // Reset state and start-up timing
    reset = 1'b1;
    tick();
    tick();
    check("rst_bclk", bus.bclk, 1'b0);
    check("rst_lrclk", bus.lrclk, 1'b0);
    check("rst_sdata", bus.sdata, 1'b0);
    check("rst_ready", bus.sample_ready, 1'b0);
    reset = 1'b0;
    release_timing();

    // Boundary-pattern frame
    bus.left_in  = 24'h800001;
    bus.right_in = 24'h7FFFFE;
    capture_frame(-1, '0, bits, lrs);
    check_frame("pat", bits, lrs, 24'h800001, Mono ? 24'h800001 : 24'h7FFFFE);

    // Frame period with held inputs
    wait_ready(cnt);
    wait_ready(cnt);
    check("ready_period", cnt, 128 * Div);

    // Mid-frame change of left_in shows up only in the following frame
    l0 = W'($urandom);
    r0 = W'($urandom);
    l1 = W'($urandom);
    bus.left_in  = l0;
    bus.right_in = r0;
    capture_frame(10, l1, bits, lrs);
    check_frame("hold", bits, lrs, l0, Mono ? l0 : r0);
    capture_frame(-1, '0, bits, lrs);
    check_frame("next", bits, lrs, l1, Mono ? l1 : r0);

    // One-clock reset at slot 40 aborts the frame and restarts timing
    wait_ready(cnt);
    for (int sl = 0; sl <= 40; sl++) wait_rise();
    reset = 1'b1;
    tick();
    check("abort_bclk", bus.bclk, 1'b0);
    check("abort_lrclk", bus.lrclk, 1'b0);
    check("abort_sdata", bus.sdata, 1'b0);
    reset = 1'b0;
    release_timing();

    // Distinct L/R words (mono build must repeat the left word)
    bus.left_in  = 24'hABCDEF;
    bus.right_in = 24'h123456;
    capture_frame(-1, '0, bits, lrs);
    check_frame("abc", bits, lrs, 24'hABCDEF, Mono ? 24'hABCDEF : 24'h123456);

    // Random inputs changing at random times, checked cycle by cycle against the model
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < int'(128 * Div); c++) begin
        if ($urandom_range(0, 63) == 0) begin
          bus.left_in  = W'($urandom);
          bus.right_in = W'($urandom);
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
